// File: rtl/arm_mem_loader_if.sv
// Byte-stream input and instruction/data memory write ports of the boot loader.
// slave = loader side, master = byte source plus memory side.
interface arm_mem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ins_we;
  logic [31:0] ins_addr;
  logic [31:0] ins_wdata;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;

  modport slave (
    input  in_data, in_valid,
    output in_ready,
    output ins_we, ins_addr, ins_wdata,
    output dmem_we, dmem_addr, dmem_wdata
  );

  modport master (
    output in_data, in_valid,
    input  in_ready,
    input  ins_we, ins_addr, ins_wdata,
    input  dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/arm_mem_loader.sv
// Boot loader: assembles little-endian words from a byte stream into instruction then data memory,
// holding the ARM core in reset until done. Define ARM_LOADER_CHECKSUM_EN for the trailing sum check.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | after reset, core held, waiting for start
// S_LOAD_INS  | receiving instruction words
// S_LOAD_DATA | receiving data words
// S_CHECK     | receiving the 4-byte expected sum (checksum build only)
// S_DONE      | load complete, core released
// S_ERROR     | sum mismatch, core held, chk_err set (checksum build only)
module arm_mem_loader #(
  parameter int INS_MEM_SIZE  = 32,
  parameter int DATA_MEM_SIZE = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  arm_mem_loader_if.slave bus,
  output logic cpu_rst,
  output logic done,
  output logic chk_err
);

  localparam int MAX_SIZE = (INS_MEM_SIZE > DATA_MEM_SIZE) ? INS_MEM_SIZE : DATA_MEM_SIZE;
  localparam int CNT_W    = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_INS,
    S_LOAD_DATA,
    S_DONE
`ifdef ARM_LOADER_CHECKSUM_EN
    , S_CHECK,
    S_ERROR
`endif
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         byte_cnt;
  logic [23:0]        word_buf;
  logic [CNT_W-1:0]   word_cnt;
  logic               accept, word_done, last_ins, last_data, begin_load;
  logic [31:0]        full_word;
  logic [31:0]        word_addr;
`ifdef ARM_LOADER_CHECKSUM_EN
  logic [31:0]        sum;
`endif

  assign accept     = bus.in_valid && bus.in_ready;
  assign word_done  = accept && (byte_cnt == 2'd3);
  assign full_word  = {bus.in_data, word_buf};
  assign word_addr  = 32'({word_cnt, 2'b00});
  assign last_ins   = (word_cnt == CNT_W'(INS_MEM_SIZE - 1));
  assign last_data  = (word_cnt == CNT_W'(DATA_MEM_SIZE - 1));
`ifdef ARM_LOADER_CHECKSUM_EN
  assign begin_load = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
`else
  assign begin_load = start && (state == S_IDLE || state == S_DONE);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_LOAD_INS;
      S_LOAD_INS:  if (word_done && last_ins) state_nxt = S_LOAD_DATA;
`ifdef ARM_LOADER_CHECKSUM_EN
      S_LOAD_DATA: if (word_done && last_data) state_nxt = S_CHECK;
      S_CHECK:     if (word_done) state_nxt = (full_word == sum) ? S_DONE : S_ERROR;
      S_ERROR:     if (start) state_nxt = S_LOAD_INS;
`else
      S_LOAD_DATA: if (word_done && last_data) state_nxt = S_DONE;
`endif
      S_DONE:      if (start) state_nxt = S_LOAD_INS;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // The final data write lands in the first DONE cycle; release the core one cycle later.
  always_comb begin
    bus.in_ready = 1'b0;
    cpu_rst      = 1'b1;
    done         = 1'b0;
    chk_err      = 1'b0;
    case (state)
      S_LOAD_INS, S_LOAD_DATA: bus.in_ready = 1'b1;
`ifdef ARM_LOADER_CHECKSUM_EN
      S_CHECK: bus.in_ready = 1'b1;
      S_ERROR: chk_err      = 1'b1;
`endif
      S_DONE: begin
        cpu_rst = bus.dmem_we;
        done    = !bus.dmem_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt       <= '0;
      word_buf       <= '0;
      word_cnt       <= '0;
      bus.ins_we     <= 1'b0;
      bus.ins_addr   <= '0;
      bus.ins_wdata  <= '0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
`ifdef ARM_LOADER_CHECKSUM_EN
      sum            <= '0;
`endif
    end else begin
      bus.ins_we  <= 1'b0;
      bus.dmem_we <= 1'b0;
      if (begin_load) begin
        byte_cnt      <= '0;
        word_cnt      <= '0;
        bus.ins_addr  <= '0;
        bus.dmem_addr <= '0;
`ifdef ARM_LOADER_CHECKSUM_EN
        sum           <= '0;
`endif
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        word_buf <= {bus.in_data, word_buf[23:8]};
        if (word_done && state == S_LOAD_INS) begin
          bus.ins_we    <= 1'b1;
          bus.ins_addr  <= word_addr;
          bus.ins_wdata <= full_word;
          word_cnt      <= last_ins ? '0 : word_cnt + 1'b1;
`ifdef ARM_LOADER_CHECKSUM_EN
          sum           <= sum + full_word;
`endif
        end
        if (word_done && state == S_LOAD_DATA) begin
          bus.dmem_we    <= 1'b1;
          bus.dmem_addr  <= word_addr;
          bus.dmem_wdata <= full_word;
          word_cnt       <= last_data ? '0 : word_cnt + 1'b1;
`ifdef ARM_LOADER_CHECKSUM_EN
          sum            <= sum + full_word;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_arm_mem_loader.sv
// Scoreboard bench for arm_mem_loader: stimulus pushes expected memory writes, a negedge monitor
// pops and compares them. Checksum scenarios run when ARM_LOADER_CHECKSUM_EN is defined.
module tb_arm_mem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cpu_rst, done, chk_err;

  arm_mem_loader_if bus ();

  arm_mem_loader #(.INS_MEM_SIZE(32), .DATA_MEM_SIZE(64)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_rst(cpu_rst), .done(done), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          ins_cnt = 0;
  int          dmem_cnt = 0;
  int          wk = 0;
  logic [31:0] msum = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ins_we && bus.dmem_we) chk("both_strobes", 1, 0);
      if (bus.ins_we || bus.dmem_we) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {bus.dmem_we, bus.ins_we}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (bus.ins_we) begin
            chk("ins_kind", 0, 32'(e.is_data));
            chk("ins_addr", bus.ins_addr, e.addr);
            chk("ins_wdata", bus.ins_wdata, e.data);
          end else begin
            chk("dmem_kind", 1, 32'(e.is_data));
            chk("dmem_addr", bus.dmem_addr, e.addr);
            chk("dmem_wdata", bus.dmem_wdata, e.data);
          end
        end
        if (bus.ins_we)  ins_cnt++;
        if (bus.dmem_we) dmem_cnt++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int   n;
    logic rdy;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin
        chk("byte_timeout", 1, 0);
        break;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    start = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_raw(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    exp_t e;
    e.is_data = (wk >= 32);
    e.addr    = (wk >= 32) ? 32'((wk - 32) * 4) : 32'(wk * 4);
    e.data    = w;
    sb.push_back(e);
    msum = msum + w;
    wk++;
    send_raw(w, gap);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wk   = 0;
    msum = '0;
  endtask

  task automatic end_load(input bit ok);
`ifdef ARM_LOADER_CHECKSUM_EN
    send_raw(ok ? msum : msum + 32'd1, 1'b0);
    @(negedge clk);
    if (ok) begin
      chk("ck_done", done, 1);
      chk("ck_cpu_rst", cpu_rst, 0);
      chk("ck_chk_err", chk_err, 0);
    end else begin
      chk("err_chk_err", chk_err, 1);
      chk("err_cpu_rst", cpu_rst, 1);
      chk("err_done", done, 0);
      chk("err_in_ready", bus.in_ready, 0);
    end
`else
    @(negedge clk);
    @(negedge clk);
    chk("end_done", done, ok ? 1 : 0);
    chk("end_cpu_rst", cpu_rst, 0);
    chk("end_in_ready", bus.in_ready, 0);
    chk("end_chk_err", chk_err, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, d0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;

    // Reset, then idle without start
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_cpu_rst", cpu_rst, 1);
      chk("idle_done", done, 0);
      chk("idle_in_ready", bus.in_ready, 0);
      chk("idle_strobes", {bus.ins_we, bus.dmem_we}, 0);
    end
    chk("idle_chk_err", chk_err, 0);

    // Full load, back-to-back bytes
    @(posedge clk);
    #1;
    i0 = ins_cnt; d0 = dmem_cnt;
    do_start();
    for (int k = 0; k < 96; k++) send_word(32'hA500_0000 + 32'(k), 1'b0);
    end_load(1'b1);
    chk("full_ins_pulses", 32'(ins_cnt - i0), 32);
    chk("full_dmem_pulses", 32'(dmem_cnt - d0), 64);

    // Start in DONE, gapped stream, then reset inside word 5
    i0 = ins_cnt;
    do_start();
    chk("restart_cpu_rst", cpu_rst, 1);
    chk("restart_done", done, 0);
    chk("restart_in_ready", bus.in_ready, 1);
    send_word(32'h1234_5678, 1'b1);
    for (int k = 1; k < 5; k++) send_word(32'h0BAD_0000 + 32'(k), 1'b1);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hDD, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) @(negedge clk);
    chk("midrst_ins_pulses", 32'(ins_cnt - i0), 5);
    chk("midrst_cpu_rst", cpu_rst, 1);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_sb_empty", 32'(sb.size()), 0);

    // Reload from IDLE with a start pulse issued during word 10
    @(posedge clk);
    #1;
    i0 = ins_cnt; d0 = dmem_cnt;
    do_start();
    for (int k = 0; k < 96; k++) begin
      if (k == 10) start = 1'b1;
      send_word(32'h3C00_0000 + 32'(k) * 32'h0001_0001, 1'b0);
    end
    end_load(1'b1);
    chk("ign_ins_pulses", 32'(ins_cnt - i0), 32);
    chk("ign_dmem_pulses", 32'(dmem_cnt - d0), 64);

`ifdef ARM_LOADER_CHECKSUM_EN
    do_start();
    for (int k = 0; k < 96; k++) send_word(32'h0000_0001, 1'b0);
    chk("ck_model_sum", msum, 32'h0000_0060);
    end_load(1'b1);
    do_start();
    for (int k = 0; k < 96; k++) send_word(32'h0000_0001, 1'b0);
    end_load(1'b0);
    for (int c = 0; c < 3; c++) @(negedge clk);
    chk("err_hold", chk_err, 1);
    #1 do_start();
    chk("err_cleared", chk_err, 0);
    chk("err_restart_in_ready", bus.in_ready, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
`endif

    for (int c = 0; c < 3; c++) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arm_mem_loader.md
Name: arm_mem_loader

Overview:
Boot-time loader sitting directly upstream of the single-cycle ARM core. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes INS_MEM_SIZE words into instruction memory, then DATA_MEM_SIZE words into data memory. The core is held in reset until the load completes, replacing simulation-only file preloading with a synthesizable path.

Parameters:
INS_MEM_SIZE, 32, number of instruction words loaded
DATA_MEM_SIZE, 64, number of data words loaded

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load from IDLE or DONE
in_data  input  8  stream byte
in_valid  input  1  source has a byte
in_ready  output  1  loader accepts a byte this cycle
ins_we  output  1  instruction memory write strobe
ins_addr  output  32  instruction memory byte address (word index * 4)
ins_wdata  output  32  instruction word
dmem_we  output  1  data memory write strobe
dmem_addr  output  32  data memory byte address (word index * 4)
dmem_wdata  output  32  data word
cpu_rst  output  1  reset to ARM core; 1 = hold in reset
done  output  1  load complete, core released
chk_err  output  1  checksum mismatch (optional feature; otherwise constant 0)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=0, ins_we=0, dmem_we=0, ins_addr=0, dmem_addr=0, ins_wdata=0, dmem_wdata=0, cpu_rst=1, done=0, chk_err=0. State goes to IDLE.
- Byte accept: a byte is accepted on a rising edge where in_valid && in_ready. When in_ready=0, the source holds its byte and the loader does not consume it.
- Byte order: the first accepted byte of a word is bits[7:0] and the fourth is bits[31:24].
- Write latency: the write strobe pulses for exactly one cycle, in the cycle after the 4th byte is accepted. addr/wdata are valid in that same cycle.
- No stall: in_ready stays high during the write cycle, so a byte stream with in_valid held high runs at 1 byte/clk.
- States:
  - IDLE: in_ready=0, cpu_rst=1. start -> LOAD_INS, with word counter, byte counter, addresses and sum cleared.
  - LOAD_INS: in_ready=1. After word INS_MEM_SIZE-1 is assembled -> LOAD_DATA; that word's ins_we pulse occurs in the first LOAD_DATA cycle.
  - LOAD_DATA: same rules, writes via dmem_*. After word DATA_MEM_SIZE-1 -> DONE, or -> CHECK when the feature is compiled in.
  - DONE: in_ready=0, cpu_rst=0, done=1. start -> LOAD_INS, with cpu_rst=1 and done=0 from the next cycle.
- Address wrap: counters never exceed SIZE-1. The last instruction address is (INS_MEM_SIZE-1)*4 = 0x7C and the last data address is 0xFC.
- start in LOAD_*/CHECK is ignored.
- Reset mid-load: discards the partial word, issues no write strobe, and returns to IDLE. Already-written memory contents are not cleared.
- Simultaneous start and rst: rst wins.
- Between strobes: ins_we and dmem_we are never high together. addr/wdata hold their last values when strobes are low.

Optional Feature:
Macro ARM_LOADER_CHECKSUM_EN.
- Enabled: the loader keeps a running 32-bit modulo-2^32 sum of every loaded word. After the last data word it enters CHECK and accepts 4 more bytes (little-endian) as the expected sum.
  - Match -> DONE.
  - Mismatch -> ERROR: in_ready=0, cpu_rst=1, done=0, chk_err=1. Only rst or start leaves ERROR; start clears chk_err and -> LOAD_INS.
- Disabled: no CHECK or ERROR state, no sum register, chk_err tied 0.

Test Plan:
- Reset check: hold rst 2 cycles, then release with no start -> cpu_rst=1, done=0, in_ready=0, no strobes for 20 cycles.
- Full load: start, then 384 bytes back-to-back where word k = 0xA5000000+k.
  - Exactly 32 ins_we pulses with addrs 0x00..0x7C, word 0 data 0xA5000000.
  - Exactly 64 dmem_we pulses with addrs 0x00..0xFC, data 0xA5000020..0xA500005F.
  - done=1 and cpu_rst=0 one cycle after the final dmem_we.
- Byte order and backpressure: in_valid toggled every other cycle, bytes 0x78,0x56,0x34,0x12 -> ins_wdata=0x12345678 at ins_addr 0. No byte is dropped or duplicated across the in_valid gaps.
- Mid-load reset: rst after 2 bytes of word 5 -> no 6th ins_we pulse. A subsequent start reloads from ins_addr 0.
- Start during load: a start pulse at word 10 -> ignored, write sequence continues unchanged. A start in DONE -> cpu_rst=1 next cycle and a new load begins at address 0.
- Checksum (ARM_LOADER_CHECKSUM_EN): all words 0x00000001 with a correct trailer 0x00000060 -> done=1. A trailer 0x00000061 -> chk_err=1, cpu_rst=1, done=0.
